apb_multi_slave_mem: RTL



---
 rtl/apb_multi_slave_mem.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/apb_multi_slave_mem.sv
// apb_multi_slave_mem
// APB4 completer backing NO_OF_SLAVES independent word-addressed memories
// selected by a one-hot pselx. Byte-strobe writes, WAIT_STATES cycles of
// pready low before completion, pslverr on range/alignment/select errors.
// Optional feature macro: APB_PROT_CHECK_EN -- when defined, non-secure
// accesses (pprot[1] = 1) to the upper half of a slave memory are rejected.
module apb_multi_slave_mem #(
    parameter int NO_OF_SLAVES  = 1,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_DEPTH     = 16,
    parameter int WAIT_STATES   = 0
) (
    input  logic                      pclk,
    input  logic                      preset_n,
    input  logic [NO_OF_SLAVES-1:0]   pselx,
    input  logic                      penable,
    input  logic                      pwrite,
    input  logic [ADDRESS_WIDTH-1:0]  paddr,
    input  logic [DATA_WIDTH-1:0]     pwdata,
    input  logic [DATA_WIDTH/8-1:0]   pstrb,
    input  logic [2:0]                pprot,
    output logic                      pready,
    output logic [DATA_WIDTH-1:0]     prdata,
    output logic                      pslverr
);

    localparam int STRB_W     = DATA_WIDTH / 8;
    localparam int ALIGN_BITS = $clog2(STRB_W);
    localparam int OFF_W      = $clog2(MEM_DEPTH);
    localparam int SEL_W      = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 1;
    localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ADDRESS_WIDTH'((1 << ALIGN_BITS) - 1);
    localparam logic [ADDRESS_WIDTH-1:0] DEPTH_A    = ADDRESS_WIDTH'(MEM_DEPTH);
    localparam logic [3:0]               WAIT_INIT  = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_READY
    } state_t;

    state_t state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;
    logic       latch_en;
    logic       commit;

    // Transfer attributes captured in the setup cycle
    logic [SEL_W-1:0]      idx_reg;
    logic                  write_reg;
    logic [OFF_W-1:0]      off_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [STRB_W-1:0]     strb_reg;
    logic                  err_reg;

    logic pready_reg;
    logic pslverr_reg;
    logic [DATA_WIDTH-1:0] prdata_reg;

    // ---------------------------------------------------------------
    // Setup-cycle decode straight from the bus
    // ---------------------------------------------------------------
    logic [ADDRESS_WIDTH-1:0] bus_offset;
    logic                     bus_onehot;
    logic                     bus_err;
    logic [SEL_W-1:0]         bus_idx;
    logic                     setup;
    logic                     unused_prot;

    assign bus_offset = paddr >> ALIGN_BITS;
    assign bus_onehot = (pselx != '0) && ((pselx & (pselx - NO_OF_SLAVES'(1))) == '0);
    assign setup      = (|pselx) && !penable;
    // pprot only influences the error flag (when enabled); it is folded
    // into err_reg at setup, so no separate copy of it is kept.
    assign unused_prot = ^pprot;

`ifdef APB_PROT_CHECK_EN
    assign bus_err = !bus_onehot
                   || (|(paddr & ALIGN_MASK))
                   || (bus_offset >= DEPTH_A)
                   || (pprot[1] && (bus_offset >= ADDRESS_WIDTH'(MEM_DEPTH / 2)));
`else
    assign bus_err = !bus_onehot
                   || (|(paddr & ALIGN_MASK))
                   || (bus_offset >= DEPTH_A);
`endif

    // One-hot to binary slave index (lowest set bit wins; multi-hot is an error anyway)
    always_comb begin
        bus_idx = '0;
        for (int i = NO_OF_SLAVES - 1; i >= 0; i--) begin
            if (pselx[i]) bus_idx = SEL_W'(i);
        end
    end

    // ---------------------------------------------------------------
    // Current-transfer view: with zero wait states the commit happens on
    // the setup edge itself, so the live bus must be used instead of the
    // latched copy.
    // ---------------------------------------------------------------
    logic                  in_idle;
    logic [SEL_W-1:0]      cur_idx;
    logic                  cur_write;
    logic [OFF_W-1:0]      cur_off;
    logic [DATA_WIDTH-1:0] cur_wdata;
    logic [STRB_W-1:0]     cur_strb;
    logic                  cur_err;

    assign in_idle   = (state_reg == S_IDLE);
    assign cur_idx   = in_idle ? bus_idx                 : idx_reg;
    assign cur_write = in_idle ? pwrite                  : write_reg;
    assign cur_off   = in_idle ? bus_offset[OFF_W-1:0]   : off_reg;
    assign cur_wdata = in_idle ? pwdata                  : wdata_reg;
    assign cur_strb  = in_idle ? pstrb                   : strb_reg;
    assign cur_err   = in_idle ? bus_err                 : err_reg;

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    // State and wait-counter registers
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state, counter and commit decision
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        latch_en   = 1'b0;
        commit     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (setup) begin
                    latch_en = 1'b1;
                    cnt_next = WAIT_INIT;
                    if (WAIT_STATES == 0) begin
                        state_next = S_READY;
                        commit     = 1'b1;
                    end else begin
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (pselx == '0) begin
                    // Requester abort: drop the transfer silently
                    state_next = S_IDLE;
                end else if (cnt_reg <= 4'd1) begin
                    state_next = S_READY;
                    commit     = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            S_READY: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Capture transfer attributes in the setup cycle
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            idx_reg   <= '0;
            write_reg <= 1'b0;
            off_reg   <= '0;
            wdata_reg <= '0;
            strb_reg  <= '0;
            err_reg   <= 1'b0;
        end else if (latch_en) begin
            idx_reg   <= bus_idx;
            write_reg <= pwrite;
            off_reg   <= bus_offset[OFF_W-1:0];
            wdata_reg <= pwdata;
            strb_reg  <= pstrb;
            err_reg   <= bus_err;
        end
    end

    // ---------------------------------------------------------------
    // Slave memories: one independent array per slave, cleared on reset
    // ---------------------------------------------------------------
    logic [DATA_WIDTH-1:0] rd_words [NO_OF_SLAVES];
    logic [DATA_WIDTH-1:0] rd_word;

    generate
        for (genvar gi = 0; gi < NO_OF_SLAVES; gi++) begin : g_slave
            logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

            // Byte-lane write on the commit edge of an error-free write to this slave
            always_ff @(posedge pclk or negedge preset_n) begin
                if (!preset_n) begin
                    for (int w = 0; w < MEM_DEPTH; w++) mem[w] <= '0;
                end else if (commit && cur_write && !cur_err && (cur_idx == SEL_W'(gi))) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (cur_strb[b]) mem[cur_off][8*b +: 8] <= cur_wdata[8*b +: 8];
                    end
                end
            end

            assign rd_words[gi] = mem[cur_off];
        end
    endgenerate

    assign rd_word = rd_words[cur_idx];

    // Registered response: only non-zero during the single READY cycle
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            pready_reg  <= 1'b0;
            pslverr_reg <= 1'b0;
            prdata_reg  <= '0;
        end else begin
            pready_reg  <= commit;
            pslverr_reg <= commit && cur_err;
            prdata_reg  <= (commit && !cur_write && !cur_err) ? rd_word : '0;
        end
    end

    assign pready  = pready_reg;
    assign pslverr = pslverr_reg;
    assign prdata  = prdata_reg;

endmodule
